// File: rtl/fp16_pkg.sv
// Shared FP16 constants, flag bit positions and the magnitude-adder state type.
package fp16_pkg;

    localparam int          FP16_BIAS    = 15;
    localparam logic [4:0]  FP16_EXP_MAX = 5'(2 * FP16_BIAS + 1);
    localparam logic [15:0] FP16_QNAN    = 16'h7E00;

    localparam int FLAG_OPERR   = 4;
    localparam int FLAG_ZERO    = 3;
    localparam int FLAG_UF      = 2;
    localparam int FLAG_OF      = 1;
    localparam int FLAG_INEXACT = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ALIGN,
        ST_ADD,
        ST_NORM,
        ST_DONE
    } magadd_state_e;

endpackage

// File: rtl/fp16_round_rne.sv
// Round-to-nearest-even on an 11-bit mantissa with guard/round/sticky.
// Shared by the FP16 add and subtract magnitude paths.
module fp16_round_rne
    import fp16_pkg::*;
(
    input  logic [10:0] mant_i,
    input  logic [5:0]  exp_i,
    input  logic        guard_i,
    input  logic        round_i,
    input  logic        sticky_i,
    output logic [10:0] mant_o,
    output logic [4:0]  exp_o,
    output logic        inexact_o,
    output logic        overflow_o
);

    logic        roundUp;
    logic [11:0] mantInc;
    logic [5:0]  expFull;

    // A carry out of the increment means the mantissa wrapped to 2.0; renormalize to 1.0.
    always_comb begin
        roundUp = guard_i & (round_i | sticky_i | mant_i[0]);
        mantInc = {1'b0, mant_i} + {11'd0, roundUp};
        if (mantInc[11]) begin
            mant_o  = mantInc[11:1];
            expFull = exp_i + 6'd1;
        end else begin
            mant_o  = mantInc[10:0];
            expFull = exp_i;
        end
        exp_o      = expFull[4:0];
        inexact_o  = guard_i | round_i | sticky_i;
        overflow_o = expFull >= {1'b0, FP16_EXP_MAX};
    end

endmodule

// File: rtl/magnitude16_add_seq.sv
// Sequential FP16 magnitude adder: align, add, normalize, RNE round, valid/ready handshake.
// Define MAGADD_FAST_ALIGN_EN for single-cycle barrel alignment instead of one bit per cycle.
module magnitude16_add_seq
    import fp16_pkg::*;
#(
    parameter int ALIGN_LIMIT = 13
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic        SIGN_A,
    input  logic        SIGN_B,
    input  logic [4:0]  IN_EXP_A_HALF,
    input  logic [4:0]  IN_EXP_B_HALF,
    input  logic [10:0] IN_MANT_A_HALF,
    input  logic [10:0] IN_MANT_B_HALF,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [15:0] Q,
    output logic [4:0]  FLAGS
);

    magadd_state_e state_q, state_d;

    logic [4:0]  expA_q, dist_q, dist_d, bigExp, inDist;
    logic [10:0] mantA_q, mantB_q, mantB_d, bigMant, smallMant;
    logic        guard_q, round_q, sticky_q, guard_d, round_d, sticky_d;
    logic [11:0] sum_q;
    logic        sign_q, operr_q, special_q;
    logic [15:0] specialRes_q, q_q, resQ;
    logic [4:0]  flags_q, resFlags;
    logic        anyNaN, anyInf, bigShift, alignDone;
    logic [10:0] normMant, rndMant;
    logic [5:0]  normExp;
    logic [4:0]  rndExp;
    logic        normG, normR, normS, rndInexact, rndOf;

    // Operand A always ends up holding the larger exponent.
    always_comb begin
        if (IN_EXP_B_HALF > IN_EXP_A_HALF) begin
            bigExp    = IN_EXP_B_HALF;
            bigMant   = IN_MANT_B_HALF;
            smallMant = IN_MANT_A_HALF;
            inDist    = IN_EXP_B_HALF - IN_EXP_A_HALF;
        end else begin
            bigExp    = IN_EXP_A_HALF;
            bigMant   = IN_MANT_A_HALF;
            smallMant = IN_MANT_B_HALF;
            inDist    = IN_EXP_A_HALF - IN_EXP_B_HALF;
        end
        anyInf = (IN_EXP_A_HALF == FP16_EXP_MAX) || (IN_EXP_B_HALF == FP16_EXP_MAX);
        anyNaN = ((IN_EXP_A_HALF == FP16_EXP_MAX) && (IN_MANT_A_HALF[9:0] != 10'd0)) ||
                 ((IN_EXP_B_HALF == FP16_EXP_MAX) && (IN_MANT_B_HALF[9:0] != 10'd0));
    end

    assign bigShift = int'(dist_q) > ALIGN_LIMIT;

`ifdef MAGADD_FAST_ALIGN_EN
    logic [41:0] alignExt;

    always_comb begin
        alignExt  = {mantB_q, 31'd0} >> dist_q;
        alignDone = 1'b1;
        dist_d    = 5'd0;
        if (bigShift) begin
            mantB_d  = 11'd0;
            guard_d  = 1'b0;
            round_d  = 1'b0;
            sticky_d = |mantB_q;
        end else begin
            mantB_d  = alignExt[41:31];
            guard_d  = alignExt[30];
            round_d  = alignExt[29];
            sticky_d = |alignExt[28:0];
        end
    end
`else
    always_comb begin
        alignDone = bigShift || (dist_q == 5'd1);
        if (bigShift) begin
            mantB_d  = 11'd0;
            guard_d  = 1'b0;
            round_d  = 1'b0;
            sticky_d = |mantB_q;
            dist_d   = 5'd0;
        end else begin
            mantB_d  = mantB_q >> 1;
            guard_d  = mantB_q[0];
            round_d  = guard_q;
            sticky_d = sticky_q | round_q;
            dist_d   = dist_q - 5'd1;
        end
    end
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Specials skip alignment but still occupy the ADD/NORM slots, giving them latency 2.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (IN_VALID) state_d = (anyInf || inDist == 5'd0) ? ST_ADD : ST_ALIGN;
            ST_ALIGN: if (alignDone) state_d = ST_ADD;
            ST_ADD:   state_d = ST_NORM;
            ST_NORM:  state_d = ST_DONE;
            ST_DONE:  if (OUT_READY) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        IN_READY  = (state_q == ST_IDLE);
        OUT_VALID = (state_q == ST_DONE);
        Q         = q_q;
        FLAGS     = flags_q;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            expA_q       <= 5'd0;
            mantA_q      <= 11'd0;
            mantB_q      <= 11'd0;
            dist_q       <= 5'd0;
            guard_q      <= 1'b0;
            round_q      <= 1'b0;
            sticky_q     <= 1'b0;
            sum_q        <= 12'd0;
            sign_q       <= 1'b0;
            operr_q      <= 1'b0;
            special_q    <= 1'b0;
            specialRes_q <= 16'd0;
            q_q          <= 16'd0;
            flags_q      <= 5'd0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (IN_VALID) begin
                        expA_q       <= bigExp;
                        mantA_q      <= bigMant;
                        mantB_q      <= smallMant;
                        dist_q       <= inDist;
                        guard_q      <= 1'b0;
                        round_q      <= 1'b0;
                        sticky_q     <= 1'b0;
                        sign_q       <= SIGN_A;
                        operr_q      <= SIGN_A ^ SIGN_B;
                        special_q    <= anyInf;
                        specialRes_q <= anyNaN ? FP16_QNAN : {SIGN_A, FP16_EXP_MAX, 10'd0};
                    end
                end
                ST_ALIGN: begin
                    mantB_q  <= mantB_d;
                    guard_q  <= guard_d;
                    round_q  <= round_d;
                    sticky_q <= sticky_d;
                    dist_q   <= dist_d;
                end
                ST_ADD:  sum_q <= {1'b0, mantA_q} + {1'b0, mantB_q};
                ST_NORM: begin
                    q_q     <= resQ;
                    flags_q <= resFlags;
                end
                default: ;
            endcase
        end
    end

    // A carry out of the sum moves the rounding point up one bit.
    always_comb begin
        if (sum_q[11]) begin
            normMant = sum_q[11:1];
            normExp  = {1'b0, expA_q} + 6'd1;
            normG    = sum_q[0];
            normR    = 1'b0;
            normS    = guard_q | round_q | sticky_q;
        end else begin
            normMant = sum_q[10:0];
            normExp  = {1'b0, expA_q};
            normG    = guard_q;
            normR    = round_q;
            normS    = sticky_q;
        end
    end

    fp16_round_rne u_round (
        .mant_i     (normMant),
        .exp_i      (normExp),
        .guard_i    (normG),
        .round_i    (normR),
        .sticky_i   (normS),
        .mant_o     (rndMant),
        .exp_o      (rndExp),
        .inexact_o  (rndInexact),
        .overflow_o (rndOf)
    );

    // A result without the hidden bit is subnormal and encodes exponent field 0.
    always_comb begin
        resFlags = 5'd0;
        if (special_q) begin
            resQ = specialRes_q;
        end else if (rndOf) begin
            resQ                   = {sign_q, FP16_EXP_MAX, 10'd0};
            resFlags[FLAG_OF]      = 1'b1;
            resFlags[FLAG_INEXACT] = 1'b1;
            resFlags[FLAG_OPERR]   = operr_q;
        end else begin
            resQ                   = {sign_q, rndMant[10] ? rndExp : 5'd0, rndMant[9:0]};
            resFlags[FLAG_ZERO]    = (rndMant == 11'd0);
            resFlags[FLAG_INEXACT] = rndInexact;
            resFlags[FLAG_OPERR]   = operr_q;
        end
        resFlags[FLAG_UF] = 1'b0;
    end

endmodule

// File: tb/tb_magnitude16_add_seq.sv
// Self-checking bench for magnitude16_add_seq: directed cases plus randomized operands
// checked against an exact-arithmetic FP16 reference.
module tb_magnitude16_add_seq;

    localparam int ALIGN_LIMIT = 13;
`ifdef MAGADD_FAST_ALIGN_EN
    localparam int TIE_LAT = 3;
`else
    localparam int TIE_LAT = 13;
`endif

    logic        CLK, RST_N, IN_VALID, IN_READY, SIGN_A, SIGN_B, OUT_VALID, OUT_READY;
    logic [4:0]  IN_EXP_A_HALF, IN_EXP_B_HALF, FLAGS;
    logic [10:0] IN_MANT_A_HALF, IN_MANT_B_HALF;
    logic [15:0] Q;

    int errors = 0;
    int checks = 0;

    magnitude16_add_seq #(.ALIGN_LIMIT(ALIGN_LIMIT)) dut (
        .CLK            (CLK),
        .RST_N          (RST_N),
        .IN_VALID       (IN_VALID),
        .IN_READY       (IN_READY),
        .SIGN_A         (SIGN_A),
        .SIGN_B         (SIGN_B),
        .IN_EXP_A_HALF  (IN_EXP_A_HALF),
        .IN_EXP_B_HALF  (IN_EXP_B_HALF),
        .IN_MANT_A_HALF (IN_MANT_A_HALF),
        .IN_MANT_B_HALF (IN_MANT_B_HALF),
        .OUT_VALID      (OUT_VALID),
        .OUT_READY      (OUT_READY),
        .Q              (Q),
        .FLAGS          (FLAGS)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Exact sum in units of 2^-24, then rounded to nearest-even FP16; returns {flags, q}.
    function automatic logic [20:0] refModel(input logic sa, input logic sb,
                                             input logic [4:0] ea, input logic [4:0] eb,
                                             input logic [10:0] ma, input logic [10:0] mb);
        longint      n, m, rem, half;
        int          e;
        logic [4:0]  f;
        logic [15:0] q;
        f = 5'd0;
        if ((ea == 5'd31 && ma[9:0] != 10'd0) || (eb == 5'd31 && mb[9:0] != 10'd0))
            return {5'd0, 16'h7E00};
        if (ea == 5'd31 || eb == 5'd31)
            return {5'd0, sa, 5'h1F, 10'd0};
        f[4] = (sa != sb);
        n = (longint'(ma) << (int'(ea) - 1)) + (longint'(mb) << (int'(eb) - 1));
        if (n < 2048) begin
            q    = {sa, 15'(n)};
            f[3] = (n == 0);
            return {f, q};
        end
        e = 1;
        while (n >= (longint'(2048) << (e - 1))) e++;
        m    = n >> (e - 1);
        rem  = n - (m << (e - 1));
        half = longint'(1) << (e - 2);
        if (rem > half || (rem == half && m[0] == 1'b1)) m++;
        if (m == 2048) begin
            m = 1024;
            e++;
        end
        f[0] = (rem != 0);
        if (e >= 31) begin
            q    = {sa, 5'h1F, 10'd0};
            f[1] = 1'b1;
            f[0] = 1'b1;
        end else begin
            q = {sa, 5'(e), 10'(m)};
        end
        return {f, q};
    endfunction

    function automatic int refLatency(input logic [4:0] ea, input logic [4:0] eb);
        int d;
        d = (ea > eb) ? int'(ea) - int'(eb) : int'(eb) - int'(ea);
        if (ea == 5'd31 || eb == 5'd31 || d == 0) return 2;
`ifdef MAGADD_FAST_ALIGN_EN
        return 3;
`else
        return (d > ALIGN_LIMIT) ? 3 : d + 2;
`endif
    endfunction

    function automatic logic [10:0] randMant(input logic [4:0] e);
        if (e == 5'd1) return 11'($urandom_range(0, 2047));
        return 11'h400 | 11'($urandom_range(0, 1023));
    endfunction

    // Called #1 after a rising edge with the DUT idle; returns #1 after the accepting edge.
    task automatic applyStimulus(input logic sa, input logic sb, input logic [4:0] ea,
                                 input logic [4:0] eb, input logic [10:0] ma, input logic [10:0] mb);
        SIGN_A = sa;
        SIGN_B = sb;
        IN_EXP_A_HALF = ea;
        IN_EXP_B_HALF = eb;
        IN_MANT_A_HALF = ma;
        IN_MANT_B_HALF = mb;
        IN_VALID = 1'b1;
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
        SIGN_A = 1'($urandom_range(0, 1));
        SIGN_B = 1'($urandom_range(0, 1));
        IN_EXP_A_HALF = 5'($urandom_range(0, 31));
        IN_EXP_B_HALF = 5'($urandom_range(0, 31));
        IN_MANT_A_HALF = 11'($urandom_range(0, 2047));
        IN_MANT_B_HALF = 11'($urandom_range(0, 2047));
    endtask

    task automatic waitResult(output int lat);
        lat = 0;
        while (OUT_VALID !== 1'b1 && lat < 64) begin
            @(posedge CLK);
            #1;
            lat++;
        end
    endtask

    task automatic consume();
        OUT_READY = 1'b1;
        @(posedge CLK);
        #1;
        OUT_READY = 1'b0;
    endtask

    task automatic runOp(input string tag, input logic sa, input logic sb,
                         input logic [4:0] ea, input logic [4:0] eb,
                         input logic [10:0] ma, input logic [10:0] mb,
                         input logic [15:0] expQ, input logic [4:0] expF, input int expLat);
        int lat;
        checkOutput({tag, "_ready"}, 32'(IN_READY), 32'd1);
        applyStimulus(sa, sb, ea, eb, ma, mb);
        waitResult(lat);
        checkOutput({tag, "_latency"}, 32'(lat), 32'(expLat));
        checkOutput({tag, "_q"}, 32'(Q), 32'(expQ));
        checkOutput({tag, "_flags"}, 32'(FLAGS), 32'(expF));
        consume();
    endtask

    initial begin
        int          lat;
        logic        sawValid;
        logic [20:0] r;

        RST_N = 1'b0;
        IN_VALID = 1'b0;
        OUT_READY = 1'b0;
        SIGN_A = 1'b0;
        SIGN_B = 1'b0;
        IN_EXP_A_HALF = 5'd0;
        IN_EXP_B_HALF = 5'd0;
        IN_MANT_A_HALF = 11'd0;
        IN_MANT_B_HALF = 11'd0;
        #12;
        checkOutput("reset_in_ready", 32'(IN_READY), 32'd1);
        checkOutput("reset_out_valid", 32'(OUT_VALID), 32'd0);
        checkOutput("reset_q", 32'(Q), 32'd0);
        checkOutput("reset_flags", 32'(FLAGS), 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;

        runOp("one_plus_one", 0, 0, 5'd15, 5'd15, 11'h400, 11'h400, 16'h4000, 5'b00000, 2);
        runOp("tie_even", 0, 0, 5'd15, 5'd4, 11'h400, 11'h400, 16'h3C00, 5'b00001, TIE_LAT);
        runOp("tie_even_swap", 0, 0, 5'd4, 5'd15, 11'h400, 11'h400, 16'h3C00, 5'b00001, TIE_LAT);
        runOp("max_overflow", 0, 0, 5'd30, 5'd30, 11'h7FF, 11'h7FF, 16'h7C00, 5'b00011, 2);
        runOp("subn_tiny", 0, 0, 5'd1, 5'd1, 11'h001, 11'h001, 16'h0002, 5'b00000, 2);
        runOp("subn_to_norm", 0, 0, 5'd1, 5'd1, 11'h3FF, 11'h001, 16'h0400, 5'b00000, 2);
        runOp("nan_in", 0, 0, 5'd31, 5'd15, 11'h600, 11'h400, 16'h7E00, 5'b00000, 2);
        runOp("inf_in", 1, 1, 5'd31, 5'd10, 11'h400, 11'h400, 16'hFC00, 5'b00000, 2);
        runOp("zero_zero", 1, 1, 5'd1, 5'd1, 11'h000, 11'h000, 16'h8000, 5'b01000, 2);
        runOp("operr", 1, 0, 5'd15, 5'd15, 11'h400, 11'h400, 16'hC000, 5'b10000, 2);
        runOp("tie_odd_up", 0, 0, 5'd15, 5'd14, 11'h401, 11'h401, 16'h3E02, 5'b00001,
              refLatency(5'd15, 5'd14));
        runOp("d13", 0, 0, 5'd20, 5'd7, 11'h7FF, 11'h7FF, 16'h53FF, 5'b00001,
              refLatency(5'd20, 5'd7));
        runOp("d14_collapse", 0, 0, 5'd20, 5'd6, 11'h7FF, 11'h7FF, 16'h53FF, 5'b00001,
              refLatency(5'd20, 5'd6));

        // Result must stay parked while the consumer stalls.
        applyStimulus(0, 0, 5'd15, 5'd15, 11'h400, 11'h400);
        waitResult(lat);
        checkOutput("bp_latency", 32'(lat), 32'd2);
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK);
            #1;
            checkOutput("bp_q_hold", 32'(Q), 32'h4000);
            checkOutput("bp_in_ready", 32'(IN_READY), 32'd0);
            checkOutput("bp_out_valid", 32'(OUT_VALID), 32'd1);
        end
        consume();
        checkOutput("bp_released", 32'(OUT_VALID), 32'd0);

        // Asynchronous reset in the middle of an alignment must drop the operation.
        applyStimulus(0, 0, 5'd15, 5'd4, 11'h400, 11'h400);
        repeat (2) @(posedge CLK);
        #2;
        RST_N = 1'b0;
        #1;
        checkOutput("midrst_in_ready", 32'(IN_READY), 32'd1);
        checkOutput("midrst_out_valid", 32'(OUT_VALID), 32'd0);
        checkOutput("midrst_q", 32'(Q), 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        sawValid = 1'b0;
        repeat (20) begin
            @(posedge CLK);
            #1;
            if (OUT_VALID === 1'b1) sawValid = 1'b1;
        end
        checkOutput("midrst_no_result", 32'(sawValid), 32'd0);

        for (int i = 0; i < 150; i++) begin
            logic       sa, sb;
            logic [4:0] ea, eb;
            logic [10:0] ma, mb;
            int k, eOther;
            sa = 1'($urandom_range(0, 1));
            sb = ($urandom_range(0, 7) == 0) ? ~sa : sa;
            ea = 5'($urandom_range(1, 30));
            k = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 16)) : int'($urandom_range(0, 29));
            eOther = (int'(ea) - k >= 1) ? int'(ea) - k : 1;
            eb = 5'(eOther);
            if ($urandom_range(0, 1) == 1) begin
                eb = ea;
                ea = 5'(eOther);
            end
            ma = randMant(ea);
            mb = randMant(eb);
            r = refModel(sa, sb, ea, eb, ma, mb);
            runOp("random", sa, sb, ea, eb, ma, mb, r[15:0], r[20:16], refLatency(ea, eb));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
